// File: rtl/mont_conv_pkg.sv
// Shared NTT definitions: modulus, coefficient width and the Montgomery
// conversion mode and FSM state types used by mont_conv.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

package mont_conv_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int Q          = `Q;

  typedef enum logic {
    MONT_TO   = 1'b0,
    MONT_FROM = 1'b1
  } mont_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mont_state_t;

endpackage

// File: rtl/mont_step.sv
// One Montgomery conversion iteration: modular doubling (TO) or modular
// halving (FROM) of an accumulator that is always kept below Q.
module mont_step
  import mont_conv_pkg::*;
#(
  parameter int WIDTH = `DATA_WIDTH,
  parameter int Q     = `Q
) (
  input  mont_mode_t       mode,
  input  logic [WIDTH:0]   acc,
  output logic [WIDTH:0]   acc_next
);

  localparam logic [WIDTH:0] QW = (WIDTH + 1)'(Q);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] sum;

  // acc < Q, so both 2*acc and acc+Q stay below 2Q and fit in WIDTH+1 bits.
  always_comb begin
    dbl      = {acc[WIDTH-1:0], 1'b0};
    sum      = acc[0] ? (acc + QW) : acc;
    acc_next = '0;
    if (mode == MONT_TO) begin
      acc_next = (dbl >= QW) ? (dbl - QW) : dbl;
    end else begin
      acc_next = sum >> 1;
    end
  end

endmodule

// File: rtl/mont_conv.sv
// Iterative conversion into (x*2^WIDTH mod Q) and out of (x*2^-WIDTH mod Q)
// the Montgomery domain, one bit per cycle, with valid/ready handshakes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif

module mont_conv
  import mont_conv_pkg::*;
#(
  parameter int WIDTH = `DATA_WIDTH,
  parameter int Q     = `Q
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] QD  = WIDTH'(Q);

  mont_state_t    state;
  mont_mode_t     mode;
  logic [WIDTH:0] acc;
  logic [WIDTH:0] acc_next;
  logic [CW-1:0]  count;

  mont_step #(.WIDTH(WIDTH), .Q(Q)) u_step (
    .mode     (mode),
    .acc      (acc),
    .acc_next (acc_next)
  );

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking write here would leak into later reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= MONT_TO;
      acc       <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mode     <= mont_mode_t'(in_mode);
            // Q is congruent to 0; folding it here keeps acc < Q throughout.
            acc      <= (in_data == QD) ? '0 : {1'b0, in_data};
            count    <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_next[WIDTH-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_conv.sv
// Directed-vector and round-trip bench for mont_conv with Q=3329, WIDTH=12.
`timescale 1ns/1ps
module tb_mont_conv;

  localparam int W = 12;
  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  mont_conv #(.WIDTH(W), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one request; all driving and sampling happens on the falling edge.
  // lat counts cycles from the accept cycle until out_valid is seen.
  task automatic run_op(input logic m, input logic [W-1:0] d, input int stall,
                        input bit push, output logic [W-1:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = ~m;
    in_data  = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check("out_valid_low_while_busy", out_valid, 0);
      @(negedge clk);
      in_data = W'($urandom);
      lat++;
    end
    res = out_data;
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    check("out_data_range", int'(out_data < W'(Q)), 1);
    for (int i = 0; i < stall; i++) begin
      in_valid = push;
      @(negedge clk);
      check("stall_data_stable", out_data, res);
      check("stall_valid_held", out_valid, 1);
      check("stall_in_ready_low", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_data_hold", out_data, res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[10];
    logic [W-1:0] res;
    logic [W-1:0] mres;
    int           lat;

    vecs[0] = '{1'b0, 12'd1,    12'd767};
    vecs[1] = '{1'b1, 12'd1,    12'd2704};
    vecs[2] = '{1'b1, 12'd767,  12'd1};
    vecs[3] = '{1'b0, 12'd0,    12'd0};
    vecs[4] = '{1'b0, 12'd3329, 12'd0};
    vecs[5] = '{1'b0, 12'd3328, 12'd2562};
    vecs[6] = '{1'b0, 12'd2,    12'd1534};
    vecs[7] = '{1'b1, 12'd2562, 12'd3328};
    vecs[8] = '{1'b1, 12'd3329, 12'd0};
    vecs[9] = '{1'b1, 12'd0,    12'd0};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].data, i % 3, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      if (i == 0) check("latency_cycles", lat, 13);
    end

    // Backpressure with a pending request that must not be taken.
    run_op(1'b0, 12'd1, 5, 1'b1, res, lat);
    check("backpressure_result", res, 767);

    // Reset in the middle of a TO_MONT(1) conversion.
    @(negedge clk);
    in_valid = 1'b1; in_mode = 1'b0; in_data = 12'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy_before_reset", busy, 1);
    rst = 1'b1;
    #1;
    check("reset_busy_async", busy, 0);
    check("reset_in_ready_async", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("no_valid_after_reset", seen, 0);
    end
    out_ready = 1'b0;
    run_op(1'b1, 12'd1, 0, 1'b0, res, lat);
    check("from_after_reset", res, 2704);

    // Round trip over random operands with random backpressure.
    for (int n = 0; n < 40; n++) begin
      int x;
      x = (n == 0) ? Q : int'($urandom_range(0, Q));
      run_op(1'b0, W'(x), int'($urandom_range(0, 3)), 1'b0, mres, lat);
      run_op(1'b1, mres, int'($urandom_range(0, 3)), 1'b0, res, lat);
      check($sformatf("roundtrip_x%0d", x), res, x % Q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
